// File: rtl/packet_classifier_pkg.sv
// pkt_cls_pkg: shared types and constants for packet_classifier.
//   - state_e      : header-tracking FSM states
//   - MAC_*/ETYPE_*: bit positions of the header fields inside a 64-bit beat
//                    (byte 0 is data[63:56])
//   - BCAST_MAC    : broadcast destination address
//   - DEF_MAX_PCKT_WORDS : default longest legal packet, in beats
//   - sat_inc8     : saturating 8-bit increment for the word counter
package pkt_cls_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    HDR_S  = 2'd1,
    BODY_S = 2'd2
  } state_e;

  // Dst MAC occupies bytes 0..5 of beat 0.
  localparam int MAC_MSB   = 63;
  localparam int MAC_LSB   = 16;
  // EtherType occupies bytes 12..13, i.e. bytes 4..5 of beat 1.
  localparam int ETYPE_MSB = 31;
  localparam int ETYPE_LSB = 16;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam int DEF_MAX_PCKT_WORDS = 190;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST bundle.
//   data/empty/sop/eop/valid/channel flow source -> sink, ready flows back.
//   modport sink : seen by a block that consumes the stream
//   modport src  : seen by a block that produces the stream
interface avalon_st_if #(
  parameter int DWIDTH = 64,
  parameter int EWIDTH = 3,
  parameter int CWIDTH = 1
);
  logic [DWIDTH-1:0] data;
  logic [EWIDTH-1:0] empty;
  logic              sop;
  logic              eop;
  logic              valid;
  logic              ready;
  logic [CWIDTH-1:0] channel;

  modport sink (input data, empty, sop, eop, valid, channel, output ready);
  modport src  (output data, empty, sop, eop, valid, channel, input ready);
endinterface

// File: rtl/ast_pipe_reg.sv
// ast_pipe_reg: one-stage Avalon-ST register slice.
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_valid/o_ready + payload: upstream side (data, empty, sop, eop, channel)
//   o_valid/i_ready + payload: downstream side, all fields registered
// o_ready = ~o_valid | i_ready, so the slice streams at full rate and holds
// every output field stable while downstream stalls.
module ast_pipe_reg #(
  parameter int DWIDTH = 64,
  parameter int EWIDTH = 3,
  parameter int CWIDTH = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [EWIDTH-1:0] i_empty,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [CWIDTH-1:0] i_channel,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic [EWIDTH-1:0] o_empty,
  output logic              o_sop,
  output logic              o_eop,
  output logic [CWIDTH-1:0] o_channel
);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [EWIDTH-1:0] r_empty;
  logic              r_sop;
  logic              r_eop;
  logic [CWIDTH-1:0] r_channel;

  assign o_ready = ~r_valid | i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_empty   <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_channel <= '0;
    end else if (i_valid && o_ready) begin
      r_valid   <= 1'b1;
      r_data    <= i_data;
      r_empty   <= i_empty;
      r_sop     <= i_sop;
      r_eop     <= i_eop;
      r_channel <= i_channel;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_empty   = r_empty;
  assign o_sop     = r_sop;
  assign o_eop     = r_eop;
  assign o_channel = r_channel;

endmodule

// File: rtl/packet_classifier.sv
// packet_classifier: tags each Ethernet packet on src_if.channel
// (1 = forward, 0 = drop) from its dst MAC and EtherType. One register
// slice of latency; beats pass unchanged apart from channel, which is only
// authoritative on the eop beat.
//   clk_i, rst_n_i : clock, async active-low reset
//   sink_if        : input stream (channel ignored)
//   src_if         : output stream with channel driven
//   mac_addr_i     : station MAC, sampled on the sop handshake
//   ethertype_i    : required EtherType (0 = any), latched on sop handshake
// Optional build macro PKT_CLASSIFIER_STATS_EN adds 32-bit wrapping
// counters pass_cnt_o, drop_cnt_o, err_cnt_o.
module packet_classifier
  import pkt_cls_pkg::*;
#(
  parameter int AST_DWIDTH     = 64,
  parameter int CHANNEL_WIDTH  = 1,
  parameter int MAX_PCKT_WORDS = DEF_MAX_PCKT_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  avalon_st_if.sink   sink_if,
  avalon_st_if.src    src_if,
  input  logic [47:0] mac_addr_i,
  input  logic [15:0] ethertype_i
`ifdef PKT_CLASSIFIER_STATS_EN
  ,
  output logic [31:0] pass_cnt_o,
  output logic [31:0] drop_cnt_o,
  output logic [31:0] err_cnt_o
`endif
);

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic        r_bad;
  logic        r_mac_hit;
  logic        r_type_hit;
  logic [15:0] r_etype;

  logic                     w_ready;
  logic                     w_acc;
  logic                     w_in_idle;
  logic                     w_pipe_vld;
  logic [47:0]              w_dst;
  logic [15:0]              w_etype;
  logic                     w_mac_hit0;
  logic                     w_type_hit1;
  logic [7:0]               w_cnt_inc;
  logic                     w_oversize;
  logic                     w_sop_mid;
  logic                     w_bad_nxt;
  logic                     w_chan_bit;
  logic [CHANNEL_WIDTH-1:0] w_chan;
  logic                     w_unused_chan;

  assign w_unused_chan = ^sink_if.channel;

  assign sink_if.ready = w_ready;
  assign w_acc         = sink_if.valid & w_ready;
  assign w_in_idle     = (r_state == IDLE_S);
  // Non-sop beats arriving between packets are accepted but never forwarded.
  assign w_pipe_vld    = sink_if.valid & ~(w_in_idle & ~sink_if.sop);

  assign w_dst       = sink_if.data[MAC_MSB:MAC_LSB];
  assign w_etype     = sink_if.data[ETYPE_MSB:ETYPE_LSB];
  assign w_mac_hit0  = (w_dst == mac_addr_i) | (w_dst == BCAST_MAC);
  assign w_type_hit1 = (r_etype == 16'h0000) | (r_etype == w_etype);

  // Bad state including the beat being accepted now, so the decision on an
  // eop beat already accounts for that beat's own length / stray sop.
  assign w_cnt_inc  = sat_inc8(r_cnt);
  assign w_oversize = (int'(w_cnt_inc) > MAX_PCKT_WORDS);
  assign w_sop_mid  = sink_if.sop & ~w_in_idle;
  assign w_bad_nxt  = r_bad | w_sop_mid | w_oversize;

  always_comb begin
    w_chan_bit = 1'b0;
    case (r_state)
      HDR_S:   w_chan_bit = r_mac_hit & w_type_hit1 & ~w_bad_nxt;
      BODY_S:  w_chan_bit = r_mac_hit & r_type_hit  & ~w_bad_nxt;
      default: w_chan_bit = 1'b0;
    endcase
    w_chan    = '0;
    w_chan[0] = w_chan_bit;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE_S;
      r_cnt      <= 8'd0;
      r_bad      <= 1'b0;
      r_mac_hit  <= 1'b0;
      r_type_hit <= 1'b0;
      r_etype    <= 16'h0000;
    end else if (w_acc) begin
      case (r_state)
        IDLE_S: begin
          if (sink_if.sop) begin
            r_cnt      <= 8'd1;
            r_bad      <= sink_if.eop;  // one-beat packet has no EtherType
            r_mac_hit  <= w_mac_hit0;
            r_type_hit <= 1'b0;
            r_etype    <= ethertype_i;
            r_state    <= sink_if.eop ? IDLE_S : HDR_S;
          end
        end
        HDR_S: begin
          r_cnt      <= w_cnt_inc;
          r_bad      <= w_bad_nxt;
          r_type_hit <= w_type_hit1;
          r_state    <= sink_if.eop ? IDLE_S : BODY_S;
        end
        BODY_S: begin
          r_cnt   <= w_cnt_inc;
          r_bad   <= w_bad_nxt;
          r_state <= sink_if.eop ? IDLE_S : BODY_S;
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

  ast_pipe_reg #(
    .DWIDTH (AST_DWIDTH),
    .EWIDTH (3),
    .CWIDTH (CHANNEL_WIDTH)
  ) u_pipe (
    .i_clk     (clk_i),
    .i_rst_n   (rst_n_i),
    .i_valid   (w_pipe_vld),
    .o_ready   (w_ready),
    .i_data    (sink_if.data),
    .i_empty   (sink_if.empty),
    .i_sop     (sink_if.sop),
    .i_eop     (sink_if.eop),
    .i_channel (w_chan),
    .o_valid   (src_if.valid),
    .i_ready   (src_if.ready),
    .o_data    (src_if.data),
    .o_empty   (src_if.empty),
    .o_sop     (src_if.sop),
    .o_eop     (src_if.eop),
    .o_channel (src_if.channel)
  );

`ifdef PKT_CLASSIFIER_STATS_EN
  // Bad flag travelling alongside the beat held in the output slice.
  logic        r_out_bad;
  logic [31:0] r_pass_cnt;
  logic [31:0] r_drop_cnt;
  logic [31:0] r_err_cnt;
  logic        w_load;
  logic        w_out_eop;
  logic        w_swallow;
  logic [31:0] w_err_add;

  assign w_load    = w_pipe_vld & w_ready;
  assign w_out_eop = src_if.valid & src_if.ready & src_if.eop;
  assign w_swallow = w_acc & w_in_idle & ~sink_if.sop;
  assign w_err_add = {31'd0, w_out_eop & r_out_bad} + {31'd0, w_swallow};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_bad  <= 1'b0;
      r_pass_cnt <= 32'd0;
      r_drop_cnt <= 32'd0;
      r_err_cnt  <= 32'd0;
    end else begin
      if (w_load)
        r_out_bad <= w_in_idle ? sink_if.eop : w_bad_nxt;
      if (w_out_eop) begin
        if (src_if.channel[0]) r_pass_cnt <= r_pass_cnt + 32'd1;
        else                   r_drop_cnt <= r_drop_cnt + 32'd1;
      end
      r_err_cnt <= r_err_cnt + w_err_add;
    end
  end

  assign pass_cnt_o = r_pass_cnt;
  assign drop_cnt_o = r_drop_cnt;
  assign err_cnt_o  = r_err_cnt;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_packet_classifier.sv
module tb_packet_classifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] mac;
  logic [15:0] etype;

  always #5 clk = ~clk;

  avalon_st_if sink_bus ();
  avalon_st_if src_bus ();

`ifdef PKT_CLASSIFIER_STATS_EN
  logic [31:0] pass_cnt, drop_cnt, err_cnt;
`endif

  packet_classifier dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sink_if     (sink_bus),
    .src_if      (src_bus),
    .mac_addr_i  (mac),
    .ethertype_i (etype)
`ifdef PKT_CLASSIFIER_STATS_EN
    ,
    .pass_cnt_o  (pass_cnt),
    .drop_cnt_o  (drop_cnt),
    .err_cnt_o   (err_cnt)
`endif
  );

  localparam logic [47:0] STA  = 48'h0011_2233_4455;
  localparam logic [47:0] OTH  = 48'h0011_2233_4456;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  empty;
    logic        sop;
    logic        eop;
    logic        chk_ch;
    logic        ch;
  } beat_t;

  typedef struct {
    string       name;
    logic [15:0] cfg_et;
    logic [47:0] dst;
    logic [15:0] et;
    int          len;
    int          mid_sop;
    logic        bad;
    logic        exp;
  } vec_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    out_beats = 0;
  int    exp_pass = 0, exp_drop = 0, exp_err = 0;
  logic  rnd_ready = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Output monitor: a handshake is visible at the negedge before the edge
  // that completes it.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && src_bus.valid && src_bus.ready) begin
      out_beats++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got data %h expected no output", src_bus.data);
      end else begin
        e = exp_q.pop_front();
        check("data", src_bus.data, e.data);
        check("sop", src_bus.sop, e.sop);
        check("eop", src_bus.eop, e.eop);
        if (e.eop) check("empty", src_bus.empty, e.empty);
        if (e.chk_ch) check(e.eop ? "eop_channel" : "sop_channel", src_bus.channel, e.ch);
      end
    end
  end

  initial begin
    src_bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 src_bus.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_accept();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sink_bus.ready && t < 200);
    if (!sink_bus.ready) begin
      n_chk++;
      $display("FAIL accept_timeout: got ready 0 expected 1 within 200 cycles");
    end
  endtask

  // Sends beats [0, stop) of a len-beat packet; mid_sop >= 1 puts a stray
  // sop on that beat.
  task automatic send_pkt(input logic [47:0] dst, input logic [15:0] et, input int len,
                          input int mid_sop, input logic bad, input logic exp, input int stop);
    beat_t b;
    for (int i = 0; i < stop; i++) begin
      b.data = {$urandom(), $urandom()};
      if (i == 0) b.data[63:16] = dst;
      if (i == 1) b.data[31:16] = et;
      b.sop    = (i == 0) || (i == mid_sop);
      b.eop    = (i == len - 1);
      b.empty  = b.eop ? 3'($urandom_range(0, 7)) : 3'd0;
      b.chk_ch = (i == 0) || b.eop;
      b.ch     = (i == 0) ? 1'b0 : exp;
      sink_bus.data  = b.data;
      sink_bus.sop   = b.sop;
      sink_bus.eop   = b.eop;
      sink_bus.empty = b.empty;
      sink_bus.valid = 1'b1;
      wait_accept();
      exp_q.push_back(b);
      if (b.eop) begin
        if (exp) exp_pass++; else exp_drop++;
        if (bad) exp_err++;
      end
      @(posedge clk);
      #1;
    end
    sink_bus.valid = 1'b0;
    sink_bus.sop   = 1'b0;
    sink_bus.eop   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef PKT_CLASSIFIER_STATS_EN
    check("pass_cnt", pass_cnt, exp_pass);
    check("drop_cnt", drop_cnt, exp_drop);
    check("err_cnt", err_cnt, exp_err);
`endif
  endtask

  vec_t vt[10];

  initial begin
    logic [47:0] dsts[3];
    int          ob;
    dsts[0] = STA; dsts[1] = BC; dsts[2] = OTH;

    vt[0] = '{"match_8",      16'h0800, STA, 16'h0800,   8, -1, 1'b0, 1'b1};
    vt[1] = '{"dst_miss",     16'h0800, OTH, 16'h0800,   8, -1, 1'b0, 1'b0};
    vt[2] = '{"bcast",        16'h0800, BC,  16'h0800,   8, -1, 1'b0, 1'b1};
    vt[3] = '{"wild_86dd",    16'h0000, STA, 16'h86DD,   5, -1, 1'b0, 1'b1};
    vt[4] = '{"etype_miss",   16'h0800, STA, 16'h0806,   6, -1, 1'b0, 1'b0};
    vt[5] = '{"len_191",      16'h0800, STA, 16'h0800, 191, -1, 1'b1, 1'b0};
    vt[6] = '{"len_190",      16'h0800, STA, 16'h0800, 190, -1, 1'b0, 1'b1};
    vt[7] = '{"single_beat",  16'h0800, STA, 16'h0800,   1, -1, 1'b1, 1'b0};
    vt[8] = '{"two_beat",     16'h0800, BC,  16'h0800,   2, -1, 1'b0, 1'b1};
    vt[9] = '{"mid_sop",      16'h0800, STA, 16'h0800,   6,  3, 1'b1, 1'b0};

    mac = STA;
    etype = 16'h0800;
    sink_bus.valid = 1'b0;
    sink_bus.data = '0;
    sink_bus.sop = 1'b0;
    sink_bus.eop = 1'b0;
    sink_bus.empty = '0;
    sink_bus.channel = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", src_bus.valid, 1'b0);
    check("rst_sop", src_bus.sop, 1'b0);
    check("rst_eop", src_bus.eop, 1'b0);
    check("rst_data", src_bus.data, 64'd0);
    check("rst_channel", src_bus.channel, 1'b0);
    check("rst_sink_ready", sink_bus.ready, 1'b1);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven packets.
    foreach (vt[k]) begin
      etype = vt[k].cfg_et;
      send_pkt(vt[k].dst, vt[k].et, vt[k].len, vt[k].mid_sop, vt[k].bad, vt[k].exp, vt[k].len);
      drain();
    end
    check_stats();

    // Three non-sop beats between packets are swallowed.
    etype = 16'h0800;
    ob = out_beats;
    for (int i = 0; i < 3; i++) begin
      sink_bus.data = {$urandom(), $urandom()};
      sink_bus.sop = 1'b0;
      sink_bus.eop = (i == 2);
      sink_bus.valid = 1'b1;
      wait_accept();
      exp_err++;
      @(posedge clk);
      #1;
    end
    sink_bus.valid = 1'b0;
    sink_bus.eop = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("swallow_no_output", out_beats, ob);
    check_stats();

    // Random backpressure, 20 back-to-back packets.
    rnd_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      logic [47:0] d;
      logic [15:0] e;
      int          len;
      logic        ex;
      d   = dsts[$urandom_range(0, 2)];
      e   = ($urandom_range(0, 2) == 0) ? 16'h86DD : 16'h0800;
      len = $urandom_range(1, 12);
      ex  = (len >= 2) && (d == STA || d == BC) && (e == 16'h0800);
      send_pkt(d, e, len, -1, len == 1, ex, len);
    end
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_stats();

    // Reset mid-packet: output register is cleared immediately.
    send_pkt(STA, 16'h0800, 8, -1, 1'b0, 1'b1, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", src_bus.valid, 1'b0);
    exp_q.delete();
    exp_pass = 0; exp_drop = 0; exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(STA, 16'h0800, 4, -1, 1'b0, 1'b1, 4);
    drain();
    check_stats();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
